mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning request address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning entries per byte bank; legal values are powers of two, 2..256.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: request accepted when high together with req_valid.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: write data, byte b at bits [8b+7:8b].
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: response consumed when high together with rsp_valid.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: read data.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: address out of range.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 Storage SHALL be 4 byte banks x DEPTH entries x 8 bits; a 32-bit word at address A SHALL occupy byte b of entry A in bank b.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-017 req_ready SHALL be high only in IDLE, combinationally from the state register.
REQ-018 On accept (IDLE, req_valid and req_ready) the block SHALL register req_write, req_addr and req_wdata; later changes on the req_* inputs SHALL have no effect.
REQ-019 On accept with req_addr < DEPTH the FSM SHALL go to ACCESS with the beat counter set to 0.
REQ-020 On accept with req_addr >= DEPTH the FSM SHALL go directly to RESP with rsp_err=1 and rsp_rdata=0, and storage SHALL NOT be modified.
REQ-021 ACCESS SHALL touch one bank per cycle, beat b = 0,1,2,3 in order; the FSM SHALL move to RESP on the edge that completes beat 3.
REQ-022 On read, beat b SHALL load bank b entry A into rsp_rdata[8b+7:8b]; on write, beat b SHALL store wdata[8b+7:8b] into bank b entry A, and rsp_rdata SHALL be 0.
REQ-023 Latency SHALL be as follows: valid requests raise rsp_valid 5 cycles after the accepting edge; error requests raise it 1 cycle after.
REQ-024 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL hold stable until rsp_ready is sampled high.
REQ-025 On the rsp handshake the FSM SHALL return to IDLE and clear rsp_valid; req_ready SHALL go high in the following cycle, so there is no same-cycle re-accept.
REQ-026 rsp_rdata and rsp_err SHALL retain their last values in IDLE.
REQ-027 req_valid while not in IDLE SHALL be ignored; the requester holds the request until it is accepted.
REQ-028 A read of an address SHALL return the data of the most recent completed write to that address.
REQ-029 The beat counter SHALL be 2 bits and SHALL wrap from 3 to 0 only on the ACCESS-to-RESP transition.

Reset
REQ-030 While rst_n=0 the block SHALL hold: FSM=IDLE, beat counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, and all storage bytes=0.
REQ-031 req_ready SHALL be 1 during reset (state IDLE); a request SHALL NOT be accepted until the first rising edge after rst_n deasserts.
REQ-032 Reset asserted mid-ACCESS or mid-RESP SHALL abort the operation immediately; no response SHALL be produced, and storage SHALL be cleared.

Verification
REQ-033 Reset, then read addr 0x0005 -> rsp_valid high 5 cycles after accept, rsp_rdata=0x00000000, rsp_err=0.
REQ-034 Write 0xDEADBEEF to 0x0003, then read 0x0003 -> rsp_rdata=0xDEADBEEF; read 0x0004 -> rsp_rdata=0x00000000.
REQ-035 Write 0x11223344 to addr 0x0010 (DEPTH=16) -> rsp_err=1 one cycle after accept; a read of 0x0000 afterwards returns its prior contents.
REQ-036 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; the next request is accepted only after the handshake.
REQ-037 Write 0xCAFEF00D to 0x000F, then assert rst_n=0 during beat 2 of a second write to 0x000F -> rsp_valid=0 immediately; after release, a read of 0x000F returns 0x00000000.
REQ-038 Back-to-back requests with req_valid held high and rsp_ready tied to 1 -> each response arrives in order, with at least one idle cycle between an rsp handshake and the next accept.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Word-addressed memory controller over four byte banks. Each access walks
// the banks one beat per cycle, then holds the response until it is consumed.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;
    localparam int unsigned NBANK = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       beat;
    logic             write_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [7:0]       mem [NBANK][DEPTH];
    logic             accept;
    logic             in_range;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < CMP_W'(DEPTH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_range ? ACCESS : RESP;
            ACCESS:  if (beat == 2'd3) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered status flags track the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= (state_nxt == RESP);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Request capture, beat counter and read-data assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= 2'd0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            write_q   <= req_write;
            idx_q     <= req_addr[IDX_W-1:0];
            wdata_q   <= req_wdata;
            beat      <= 2'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= !in_range;
        end else if (state == ACCESS) begin
            beat <= beat + 2'd1;
            if (!write_q) begin
                rsp_rdata[{beat, 3'b000} +: 8] <= mem[beat][idx_q];
            end
        end
    end

    // Byte banks; reset clears every entry, including mid-operation aborts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < int'(NBANK); b++) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    mem[b][e] <= 8'd0;
                end
            end
        end else if (state == ACCESS && write_q) begin
            mem[beat][idx_q] <= wdata_q[{beat, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: word-level memory model plus a per-cycle
// response checker and literal expectations.
module tb_mem_access_ctrl;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned IW     = $clog2(DEPTH);

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_ready = 1'b0;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err   = 1'b0;
    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle checker: response payload, handshake exclusivity, idle retention
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            end else if (!busy) begin
                chk("idle_retain_rdata", rsp_rdata, exp_rdata);
                chk("idle_retain_err", 32'(rsp_err), 32'(exp_err));
            end
            chk("busy_vs_ready", 32'(busy), 32'(!req_ready));
        end
    end

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'd0;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
    endtask

    // One transaction; latency = rising edges from accept to first edge seeing rsp_valid
    task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                          input int hold, input bit b2b,
                          output logic [31:0] rdo, output logic ero);
        int   n;
        int   lat;
        logic e;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        if (b2b) rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        e         = (32'(a) >= DEPTH);
        exp_err   = e;
        exp_rdata = (e || wr) ? 32'd0 : model[a[IW-1:0]];
        if (!e && wr) model[a[IW-1:0]] = wd;
        if (!b2b) begin
            #1;
            req_valid = 1'b0;
            req_write = ~wr;
            req_addr  = ~a;
            req_wdata = ~wd;
        end
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), e ? 32'd1 : 32'd5);
        rdo = rsp_rdata;
        ero = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(req_ready), 32'd1);
        if (!b2b) rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b0, 16'h0005, 32'd0, 0, 1'b0, rd, er);
        chk("rd5_lit", rd, 32'h0000_0000);
        chk("rd5_err_lit", 32'(er), 32'd0);

        do_req(1'b1, 16'h0003, 32'hDEAD_BEEF, 0, 1'b0, rd, er);
        chk("wr3_rdata_lit", rd, 32'h0000_0000);
        do_req(1'b0, 16'h0003, 32'd0, 0, 1'b0, rd, er);
        chk("rd3_lit", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 16'h0004, 32'd0, 0, 1'b0, rd, er);
        chk("rd4_lit", rd, 32'h0000_0000);

        do_req(1'b1, 16'h0000, 32'h0BAD_F00D, 0, 1'b0, rd, er);
        do_req(1'b1, 16'h0010, 32'h1122_3344, 0, 1'b0, rd, er);
        chk("wr10_err_lit", 32'(er), 32'd1);
        chk("wr10_rdata_lit", rd, 32'h0000_0000);
        do_req(1'b0, 16'h0000, 32'd0, 0, 1'b0, rd, er);
        chk("rd0_lit", rd, 32'h0BAD_F00D);
        do_req(1'b0, 16'hFFFF, 32'd0, 2, 1'b0, rd, er);
        chk("rdffff_err_lit", 32'(er), 32'd1);

        do_req(1'b0, 16'h0003, 32'd0, 10, 1'b0, rd, er);
        chk("rd3_hold_lit", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 16'h000F, 32'hCAFE_F00D, 0, 1'b0, rd, er);
        do_req(1'b0, 16'h000F, 32'd0, 0, 1'b0, rd, er);
        chk("rdF_lit", rd, 32'hCAFE_F00D);

        // Abort a second write to 0xF during beat 2
        req_write = 1'b1;
        req_addr  = 16'h000F;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rdata", rsp_rdata, 32'd0);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 16'h000F, 32'd0, 0, 1'b0, rd, er);
        chk("rdF_after_abort_lit", rd, 32'h0000_0000);
        do_req(1'b0, 16'h0003, 32'd0, 0, 1'b0, rd, er);
        chk("rd3_after_abort_lit", rd, 32'h0000_0000);

        // Back-to-back with req_valid and rsp_ready held high
        do_req(1'b1, 16'h0001, 32'hA5A5_0001, 0, 1'b1, rd, er);
        do_req(1'b1, 16'h0002, 32'h5A5A_0002, 0, 1'b1, rd, er);
        do_req(1'b0, 16'h0001, 32'd0, 0, 1'b1, rd, er);
        chk("b2b_rd1_lit", rd, 32'hA5A5_0001);
        do_req(1'b0, 16'h0030, 32'd0, 0, 1'b1, rd, er);
        chk("b2b_err_lit", 32'(er), 32'd1);
        do_req(1'b0, 16'h0002, 32'd0, 0, 1'b1, rd, er);
        chk("b2b_rd2_lit", rd, 32'h5A5A_0002);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
